// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter slice: word and RAM status
// encodings plus the arbiter grant states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    localparam int STREAK_W = 4;

    function automatic logic ram_done(input ramstate_t s);
        return (s == ACCESS);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/RAM side bundle of the memory arbiter; slave is the arbiter view,
// master is the view of the caches and RAM model that surround it.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      merr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
    );

endinterface

// File: rtl/arb_streak_ctr.sv
// Saturating count of back-to-back data completions seen while an
// instruction fetch is waiting; sat tells the arbiter to yield to the fetch.
module arb_streak_ctr
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [STREAK_W-1:0] MAX_C = STREAK_W'(DSTREAK_MAX);

    logic [STREAK_W-1:0] cnt_r;
    logic [STREAK_W-1:0] cnt_nxt_s;

    // Next count: clear wins over increment, and the count stops at the limit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {STREAK_W{1'b0}};
        end else if (inc && (cnt_r < MAX_C)) begin
            cnt_nxt_s = cnt_r + {{(STREAK_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Streak register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r <= {STREAK_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign sat = (cnt_r == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: data side wins by
// default, a bounded data streak guarantees instruction fetches progress.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX   = 4,
    parameter bit RAM_ERR_RETRY = 1'b1
) (
    input  logic            CLK,
    input  logic            nRST,
    mem_arbiter_if.slave    bus
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;

    logic  d_req_s;
    logic  iwait_s;
    logic  dwait_s;
    logic  ram_ren_s;
    logic  ram_wen_s;
    word_t ram_addr_s;
    word_t ram_store_s;
    logic  merr_s;
    logic  streak_inc_s;
    logic  streak_clr_s;
    logic  streak_sat_s;

    assign d_req_s = bus.dREN | bus.dWEN;

    arb_streak_ctr #(
        .DSTREAK_MAX (DSTREAK_MAX)
    ) u_streak (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (streak_inc_s),
        .clr  (streak_clr_s),
        .sat  (streak_sat_s)
    );

    // Grant state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next grant and RAM-side muxing from the state and the granted requester.
    always_comb begin
        state_nxt_s  = state_r;
        iwait_s      = 1'b1;
        dwait_s      = 1'b1;
        ram_ren_s    = 1'b0;
        ram_wen_s    = 1'b0;
        ram_addr_s   = 32'h0000_0000;
        ram_store_s  = 32'h0000_0000;
        merr_s       = 1'b0;
        streak_inc_s = 1'b0;
        streak_clr_s = ~bus.iREN;

        case (state_r)
            IDLE: begin
                if (d_req_s && !(bus.iREN && streak_sat_s)) begin
                    state_nxt_s = DGRANT;
                end else if (bus.iREN) begin
                    state_nxt_s = IGRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            IGRANT: begin
                ram_ren_s  = bus.iREN;
                ram_addr_s = bus.iaddr;
                if (ram_done(bus.ramstate)) begin
                    iwait_s      = 1'b0;
                    streak_clr_s = 1'b1;
                    state_nxt_s  = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    state_nxt_s = IDLE;
                    if (!RAM_ERR_RETRY) begin
                        merr_s  = 1'b1;
                        iwait_s = 1'b0;
                    end else begin
                        merr_s  = 1'b0;
                    end
                end else if (!bus.iREN) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = IGRANT;
                end
            end

            DGRANT: begin
                // A simultaneous read and write request is served as the write.
                ram_wen_s   = bus.dWEN;
                ram_ren_s   = bus.dREN & ~bus.dWEN;
                ram_addr_s  = bus.daddr;
                ram_store_s = bus.dstore;
                if (ram_done(bus.ramstate)) begin
                    dwait_s      = 1'b0;
                    streak_inc_s = bus.iREN;
                    state_nxt_s  = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    state_nxt_s = IDLE;
                    if (!RAM_ERR_RETRY) begin
                        merr_s  = 1'b1;
                        dwait_s = 1'b0;
                    end else begin
                        merr_s  = 1'b0;
                    end
                end else if (!d_req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DGRANT;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign bus.iwait    = iwait_s;
    assign bus.dwait    = dwait_s;
    assign bus.ramREN   = ram_ren_s;
    assign bus.ramWEN   = ram_wen_s;
    assign bus.ramaddr  = ram_addr_s;
    assign bus.ramstore = ram_store_s;
    assign bus.merr     = merr_s;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (error retry on / off) share one
// stimulus stream and are compared cycle by cycle with a reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int DMAX = 4;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus_a ();
    mem_arbiter_if bus_b ();

    mem_arbiter #(.DSTREAK_MAX(DMAX), .RAM_ERR_RETRY(1'b1)) dut_retry (
        .CLK (CLK), .nRST (nRST), .bus (bus_a)
    );
    mem_arbiter #(.DSTREAK_MAX(DMAX), .RAM_ERR_RETRY(1'b0)) dut_drop (
        .CLK (CLK), .nRST (nRST), .bus (bus_b)
    );

    int tests_run = 0;
    int fail_cnt  = 0;

    // model state per instance: 0 = retry on, 1 = retry off
    int owner  [2];
    int streak [2];

    // last observed outputs, for scenario-level checks
    logic  obs_iwait [2];
    logic  obs_dwait [2];
    logic  obs_ren   [2];
    logic  obs_wen   [2];
    logic  obs_merr  [2];
    word_t obs_store [2];
    word_t obs_iload [2];

    logic      ir, dr, dw;
    word_t     ia, da, ds, rl;
    ramstate_t rs;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_bus(input int k, input logic iw, input logic dwt, input logic ren,
                             input logic wen, input word_t addr, input word_t store,
                             input logic merr, input word_t iload, input word_t dload);
        logic  e_iw, e_dw, e_ren, e_wen, e_merr, dq, req, done, unblock;
        word_t e_addr, e_store;
        int    nown;
        bit    retry;
        retry   = (k == 0);
        e_iw    = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0; e_merr = 1'b0;
        e_addr  = 32'h0; e_store = 32'h0;
        dq      = dr | dw;
        nown    = owner[k];
        done    = 1'b0;
        unblock = 1'b0;
        if (owner[k] == OWN_NONE) begin
            if (dq && !(ir && streak[k] == DMAX)) nown = OWN_D;
            else if (ir)                           nown = OWN_I;
        end else begin
            if (owner[k] == OWN_I) begin
                req = ir; e_ren = ir; e_addr = ia;
            end else begin
                req = dq; e_wen = dw; e_ren = dr && !dw; e_addr = da; e_store = ds;
            end
            if (rs == ACCESS) begin
                done = 1'b1; unblock = 1'b1; nown = OWN_NONE;
            end else if (rs == ERROR) begin
                nown = OWN_NONE;
                if (!retry) begin unblock = 1'b1; e_merr = 1'b1; end
            end else if (!req) begin
                nown = OWN_NONE;
            end
            if (unblock) begin
                if (owner[k] == OWN_I) e_iw = 1'b0;
                else                   e_dw = 1'b0;
            end
        end
        check_val($sformatf("iwait[%0d]", k),    32'(iw),    32'(e_iw));
        check_val($sformatf("dwait[%0d]", k),    32'(dwt),   32'(e_dw));
        check_val($sformatf("ramREN[%0d]", k),   32'(ren),   32'(e_ren));
        check_val($sformatf("ramWEN[%0d]", k),   32'(wen),   32'(e_wen));
        check_val($sformatf("ramaddr[%0d]", k),  addr,       e_addr);
        check_val($sformatf("ramstore[%0d]", k), store,      e_store);
        check_val($sformatf("merr[%0d]", k),     32'(merr),  32'(e_merr));
        check_val($sformatf("iload[%0d]", k),    iload,      rl);
        check_val($sformatf("dload[%0d]", k),    dload,      rl);
        obs_iwait[k] = iw;  obs_dwait[k] = dwt; obs_ren[k] = ren; obs_wen[k] = wen;
        obs_merr[k]  = merr; obs_store[k] = store; obs_iload[k] = iload;
        if (!nRST) begin
            owner[k] = OWN_NONE; streak[k] = 0;
        end else begin
            if (!ir || (owner[k] == OWN_I && done))                    streak[k] = 0;
            else if (owner[k] == OWN_D && done && streak[k] < DMAX)   streak[k] = streak[k] + 1;
            owner[k] = nown;
        end
    endtask

    task automatic step(input logic ir_i, input word_t ia_i, input logic dr_i, input logic dw_i,
                        input word_t da_i, input word_t ds_i, input ramstate_t rs_i, input word_t rl_i);
        ir = ir_i; ia = ia_i; dr = dr_i; dw = dw_i; da = da_i; ds = ds_i; rs = rs_i; rl = rl_i;
        bus_a.iREN = ir; bus_a.iaddr = ia; bus_a.dREN = dr; bus_a.dWEN = dw;
        bus_a.daddr = da; bus_a.dstore = ds; bus_a.ramstate = rs; bus_a.ramload = rl;
        bus_b.iREN = ir; bus_b.iaddr = ia; bus_b.dREN = dr; bus_b.dWEN = dw;
        bus_b.daddr = da; bus_b.dstore = ds; bus_b.ramstate = rs; bus_b.ramload = rl;
        #3;
        check_bus(0, bus_a.iwait, bus_a.dwait, bus_a.ramREN, bus_a.ramWEN, bus_a.ramaddr,
                  bus_a.ramstore, bus_a.merr, bus_a.iload, bus_a.dload);
        check_bus(1, bus_b.iwait, bus_b.dwait, bus_b.ramREN, bus_b.ramWEN, bus_b.ramaddr,
                  bus_b.ramstore, bus_b.merr, bus_b.iload, bus_b.dload);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endtask

    initial begin
        int ren_cnt, iw_low, d_before, d_between, i_done;
        bit irq, drq, dwq;
        owner[0] = OWN_NONE; owner[1] = OWN_NONE; streak[0] = 0; streak[1] = 0;
        @(posedge CLK); #1;
        // reset values with requests asserted
        step(1'b1, 32'h44, 1'b1, 1'b1, 32'h88, 32'h99, ACCESS, 32'h5);
        nRST = 1'b1;
        idle_steps(1);

        // reset while a write is held in BUSY
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h77, BUSY, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h77, BUSY, 32'h0);
        check_val("wen_before_reset", 32'(obs_wen[0]), 32'h1);
        nRST = 1'b0;
        owner[0] = OWN_NONE; owner[1] = OWN_NONE; streak[0] = 0; streak[1] = 0;
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h77, BUSY, 32'h0);
        check_val("wen_in_reset", 32'(obs_wen[0]), 32'h0);
        check_val("dwait_in_reset", 32'(obs_dwait[0]), 32'h1);
        nRST = 1'b1;
        idle_steps(2);

        // fetch completing on the third grant cycle
        ren_cnt = 0; iw_low = 0;
        step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, (i == 2) ? ACCESS : BUSY,
                 (i == 2) ? 32'hDEAD_BEEF : 32'h0);
            if (obs_ren[0]) ren_cnt++;
            if (!obs_iwait[0]) begin
                iw_low++;
                check_val("iload_fetch", obs_iload[0], 32'hDEAD_BEEF);
            end
        end
        check_val("fetch_ren_cycles", 32'(ren_cnt), 32'd3);
        check_val("fetch_iwait_low", 32'(iw_low), 32'd1);
        idle_steps(1);

        // simultaneous fetch and write: write first, fetch after
        step(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'h1234, BUSY, 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'h1234, BUSY, 32'h0);
        check_val("dfirst_wen", 32'(obs_wen[0]), 32'h1);
        check_val("dfirst_store", obs_store[0], 32'h1234);
        step(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'h1234, ACCESS, 32'h0);
        check_val("dfirst_dwait", 32'(obs_dwait[0]), 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h11);
        check_val("ithen_iwait", 32'(obs_iwait[0]), 32'h0);

        // read+write both high is served as a write
        idle_steps(1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hC0, 32'h5A, BUSY, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hC0, 32'h5A, BUSY, 32'h0);
        check_val("rw_wen", 32'(obs_wen[0]), 32'h1);
        check_val("rw_ren", 32'(obs_ren[0]), 32'h0);
        idle_steps(2);

        // data streak limit with a pending fetch
        d_before = 0; d_between = 0; i_done = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, ACCESS, 32'(i));
            if (!obs_iwait[0])      i_done++;
            else if (!obs_dwait[0]) begin
                if (i_done == 0)      d_before++;
                else if (i_done == 1) d_between++;
            end
        end
        check_val("streak_d_before", 32'(d_before), 32'(DMAX));
        check_val("streak_d_between", 32'(d_between), 32'(DMAX));
        check_val("streak_i_done", 32'(i_done), 32'd2);
        idle_steps(2);

        // error during a fetch: retry vs drop
        step(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        step(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, ERROR, 32'h0);
        check_val("err_merr_drop", 32'(obs_merr[1]), 32'h1);
        check_val("err_iwait_drop", 32'(obs_iwait[1]), 32'h0);
        check_val("err_merr_retry", 32'(obs_merr[0]), 32'h0);
        check_val("err_iwait_retry", 32'(obs_iwait[0]), 32'h1);
        step(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        check_val("err_idle_ren", 32'(obs_ren[0]), 32'h0);
        step(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        check_val("err_reissue_ren", 32'(obs_ren[0]), 32'h1);
        idle_steps(2);

        // randomized traffic
        irq = 1'b0; drq = 1'b0; dwq = 1'b0;
        for (int i = 0; i < 800; i++) begin
            int r;
            ramstate_t rsr;
            if ($urandom_range(0, 5) == 0) irq = ~irq;
            if ($urandom_range(0, 4) == 0) drq = ~drq;
            if ($urandom_range(0, 6) == 0) dwq = ~dwq;
            r = $urandom_range(0, 19);
            if (r < 6)       rsr = ACCESS;
            else if (r < 13) rsr = BUSY;
            else if (r < 16) rsr = FREE;
            else             rsr = ERROR;
            step(irq, $urandom, drq, dwq, $urandom, $urandom, rsr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
